assoc_cache_controller: RTL and testbench

- Parametrised N-way set-associative cache level controller with on-block tag, valid and data storage.
- Replaces the fixed-geometry, externally fed L1/L2 controllers.
- Accepts CPU-side requests through a valid/ready handshake, performs lookup, and refills read misses from the next level through a req/ack handshake. Writes are write-through.
- Also provides round-robin replacement, a full-array flush, and saturating hit/miss counters.

---
 rtl/assoc_cache_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_assoc_cache_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache_controller.sv
// N-way set-associative cache controller: lookup, read-miss refill, write-through, round-robin victims.
// Read hit responds two cycles after accept; misses and writes respond one cycle after mem_ack.
module assoc_cache_controller #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 8,
    parameter int OFFSET_BITS = 6,
    parameter int INDEX_BITS  = 2,
    parameter int WAYS        = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int SETS  = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - OFFSET_BITS - INDEX_BITS;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_REFILL = 3'd2;
    localparam logic [2:0] S_WTHRU  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [WAY_W-1:0]  vptr_q [SETS];
    logic [WAY_W-1:0]  vptr_d [SETS];
    logic [TAG_W-1:0]  tag_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_d [SETS][WAYS];
    logic [DATA_W-1:0] data_q [SETS][WAYS];
    logic [DATA_W-1:0] data_d [SETS][WAYS];
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic              resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit, victim_from_ptr;
    logic [WAY_W-1:0]      hit_way, victim_way;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign idx = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign tag = addr_q[ADDR_W-1 -: TAG_W];

    // Victim prefers the lowest invalid way; the pointer is only consulted when the set is full.
    always_comb begin
        hit             = 1'b0;
        hit_way         = '0;
        victim_from_ptr = 1'b1;
        victim_way      = vptr_q[idx];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                victim_from_ptr = 1'b0;
                victim_way      = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        valid_d      = valid_q;
        vptr_d       = vptr_q;
        tag_d        = tag_q;
        data_d       = data_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = resp_hit_q;
        resp_rdata_d = resp_rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    for (int s = 0; s < SETS; s++) begin
                        valid_d[s] = '0;
                        vptr_d[s]  = '0;
                    end
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                resp_hit_d = hit;
                if (hit) hit_cnt_d = sat_inc(hit_cnt_q);
                else     miss_cnt_d = sat_inc(miss_cnt_q);
                if (hit && !we_q) begin
                    resp_rdata_d = data_q[idx][hit_way];
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = we_q;
                    mem_addr_d  = {addr_q[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    mem_wdata_d = wdata_q;
                    if (hit) data_d[idx][hit_way] = wdata_q;
                    state_d = we_q ? S_WTHRU : S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_ack) begin
                    tag_d[idx][victim_way]   = tag;
                    data_d[idx][victim_way]  = mem_rdata;
                    valid_d[idx][victim_way] = 1'b1;
                    if (victim_from_ptr) begin
                        vptr_d[idx] = (vptr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : vptr_q[idx] + WAY_W'(1);
                    end
                    resp_rdata_d = mem_rdata;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_WTHRU: begin
                if (mem_ack) begin
                    resp_rdata_d = '0;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                vptr_q[s]  <= '0;
            end
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            valid_q      <= valid_d;
            vptr_q       <= vptr_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_rdata_q <= resp_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Tag and data storage carry no reset; valid bits alone decide residency.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign req_ready  = (state_q == S_IDLE) && !flush;
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
endmodule

// File: tb/tb_assoc_cache_controller.sv
// Scoreboard bench for assoc_cache_controller: random requests against a set/way model with a backing memory.
module tb_assoc_cache_controller;
    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_we, mem_ack;
    logic [31:0] req_addr, mem_addr;
    logic [7:0]  req_wdata, mem_wdata, mem_rdata, resp_rdata;
    logic        req_ready, resp_valid, resp_hit, mem_req, mem_we;
    logic [15:0] hit_count, miss_count;

    assoc_cache_controller dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit hit; logic [7:0] rdata; bit uses_mem; int acc; int hits; int misses; } exp_t;
    typedef struct { bit we; logic [31:0] addr; logic [7:0] wdata; } mexp_t;
    exp_t  sbq[$];
    mexp_t memq[$];

    int passed = 0, total = 0;
    int last_ack = 0;
    bit mem_active = 0, hold_ack = 0;
    logic [7:0] bmem [logic [31:0]];

    // Reference model: per set, WAYS=2 slots holding (valid, tag, data) plus a round-robin pointer.
    bit          mv [4][2];
    logic [23:0] mt [4][2];
    logic [7:0]  md [4][2];
    int          mp [4];
    int          m_hits = 0, m_misses = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    endtask

    task automatic fail(input string nm);
        total++;
        $display("FAIL %s: timed out or unexpected event", nm);
    endtask

    function automatic logic [7:0] mem_val(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return a[13:6] ^ a[21:14] ^ 8'h3C;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 4; s++) begin
            mp[s] = 0;
            for (int w = 0; w < 2; w++) mv[s][w] = 0;
        end
    endtask

    task automatic model_req(input logic [31:0] a, input bit we, input logic [7:0] wd, input int acc);
        exp_t e;
        logic [31:0] line;
        int ix, hw, v;
        logic [23:0] tg;
        bit h;
        line = a & 32'hFFFF_FFC0;
        ix = int'(a[7:6]);
        tg = a[31:8];
        h = 0; hw = 0;
        for (int w = 0; w < 2; w++) if (mv[ix][w] && mt[ix][w] == tg) begin h = 1; hw = w; end
        if (h) m_hits++; else m_misses++;
        e.hit = h; e.acc = acc; e.uses_mem = we || !h;
        if (!we) begin
            if (h) e.rdata = md[ix][hw];
            else begin
                v = -1;
                for (int w = 0; w < 2; w++) if (!mv[ix][w] && v < 0) v = w;
                if (v < 0) begin v = mp[ix]; mp[ix] = (mp[ix] + 1) % 2; end
                mv[ix][v] = 1; mt[ix][v] = tg; md[ix][v] = mem_val(line);
                e.rdata = md[ix][v];
            end
        end else begin
            e.rdata = 8'h00;
            if (h) md[ix][hw] = wd;
        end
        e.hits = m_hits; e.misses = m_misses;
        if (e.uses_mem) memq.push_back('{we, line, wd});
        sbq.push_back(e);
    endtask

    task automatic do_req(input logic [31:0] a, input bit we, input logic [7:0] wd);
        int n;
        @(posedge clk); #1;
        req_valid = 1; req_addr = a; req_we = we; req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready) begin
            n++;
            if (n > 50) begin fail("req_accept"); req_valid = 0; return; end
            @(negedge clk);
        end
        model_req(a, we, wd, cyc);
        @(posedge clk); #1;
        req_valid = 0; req_addr = $urandom; req_we = 1'($urandom); req_wdata = 8'($urandom);
        n = 0;
        while (sbq.size() != 0 || memq.size() != 0 || mem_active) begin
            @(posedge clk); #1;
            n++;
            if (n > 100) begin fail("resp_wait"); sbq.delete(); memq.delete(); break; end
        end
    endtask

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (sbq.size() == 0) fail("unexpected_resp");
                else begin
                    e = sbq.pop_front();
                    check("resp_hit", 32'(resp_hit), 32'(e.hit));
                    check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                    check("resp_latency", cyc, e.uses_mem ? last_ack + 1 : e.acc + 2);
                    check("hit_count", 32'(hit_count), e.hits);
                    check("miss_count", 32'(miss_count), e.misses);
                end
            end
        end
    end

    // Next-level memory with random ack delay
    initial begin
        mexp_t me;
        int wait_n;
        mem_ack = 0; mem_rdata = 0; wait_n = 0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 0;
            if (rst || hold_ack) begin mem_active = 0; continue; end
            if (mem_req && !mem_active) begin
                mem_active = 1;
                wait_n = $urandom_range(0, 3);
                if (memq.size() == 0) fail("unexpected_mem_req");
                else begin
                    me = memq.pop_front();
                    check("mem_we", 32'(mem_we), 32'(me.we));
                    check("mem_addr", mem_addr, me.addr);
                    if (me.we) check("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
                end
            end
            if (mem_active) begin
                if (wait_n == 0) begin
                    mem_ack = 1; mem_active = 0; last_ack = cyc;
                    if (mem_we) bmem[mem_addr] = mem_wdata;
                    else mem_rdata = mem_val(mem_addr);
                end else wait_n--;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a;
        rst = 1; flush = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        bmem[32'h0000_1040] = 8'hA5;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_hit_count", 32'(hit_count), 0);
        check("rst_miss_count", 32'(miss_count), 0);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_mem_req", 32'(mem_req), 0);

        do_req(32'h0000_1040, 0, 8'h00);
        do_req(32'h0000_1040, 0, 8'h00);
        do_req(32'h0000_2040, 0, 8'h00);
        do_req(32'h0000_3040, 0, 8'h00);
        do_req(32'h0000_2040, 0, 8'h00);
        do_req(32'h0000_1040, 0, 8'h00);
        do_req(32'h0000_2040, 1, 8'h5A);
        do_req(32'h0000_2040, 0, 8'h00);
        do_req(32'h0000_5040, 1, 8'h77);
        do_req(32'h0000_5040, 0, 8'h00);

        @(posedge clk); #1;
        flush = 1; req_valid = 1; req_addr = 32'h0000_2040; req_we = 0;
        #1 check("flush_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        flush = 0; req_valid = 0;
        model_clear();
        #1 check("post_flush_ready", 32'(req_ready), 1);
        do_req(32'h0000_2040, 0, 8'h00);

        hold_ack = 1;
        @(posedge clk); #1;
        req_valid = 1; req_addr = 32'h0000_2080; req_we = 0;
        @(posedge clk); #1;
        req_valid = 0;
        n = 0;
        while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
        check("abort_mem_req_up", 32'(mem_req), 1);
        check("abort_mem_addr", mem_addr, 32'h0000_2080);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        check("abort_mem_req_drop", 32'(mem_req), 0);
        check("abort_hit_count", 32'(hit_count), 0);
        check("abort_miss_count", 32'(miss_count), 0);
        check("abort_req_ready", 32'(req_ready), 1);
        model_clear();
        m_hits = 0; m_misses = 0;
        hold_ack = 0;
        do_req(32'h0000_2040, 0, 8'h00);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                @(posedge clk); #1 flush = 1;
                @(posedge clk); #1 flush = 0;
                model_clear();
            end
            a = (32'($urandom_range(1, 5)) << 8) | (32'($urandom_range(0, 3)) << 6) | 32'($urandom_range(0, 63));
            do_req(a, ($urandom_range(0, 9) < 3), 8'($urandom));
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
